// File: rtl/pci_target_mem_if.sv
// pci_target_mem_if: control and handshake signals shared by a PCI-style
// initiator and target. All strobes are active-low. The multiplexed AD bus
// is not part of this bundle; it stays a plain inout on the target so its
// tristate resolves at an ordinary module boundary.
interface pci_target_mem_if;
  logic       FRAME;
  logic [3:0] CBE;
  logic       IRDY;
  logic       TRDY;
  logic       DEVSEL;

  modport master (
    output FRAME,
    output CBE,
    output IRDY,
    input  TRDY,
    input  DEVSEL
  );

  modport slave (
    input  FRAME,
    input  CBE,
    input  IRDY,
    output TRDY,
    output DEVSEL
  );
endinterface

// File: rtl/pci_target_mem.sv
// pci_target_mem: simplified 32-bit PCI memory target backed by a small word
// memory. Claims Memory Read (0110) and Memory Write (0111) transactions
// whose address falls in the BASE_ADDR window, then moves burst data on the
// IRDY#/TRDY# handshake with a linearly incrementing, wrapping word index.
// Optional build macro BYTE_ENABLE_EN: when defined, write transfers honour
// the active-low byte enables on CBE; otherwise every write stores all 32 bits.
module pci_target_mem #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int unsigned MEM_WORDS = 16
) (
  input  logic            CLK,
  input  logic            RST,
  pci_target_mem_if.slave bus,
  inout  wire  [31:0]     AD
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  localparam logic [3:0] CmdMemRead  = 4'b0110;
  localparam logic [3:0] CmdMemWrite = 4'b0111;

  typedef enum logic [2:0] {
    StIdle,
    StWriteData,
    StReadTa,
    StReadData,
    StIgnore
  } state_e;

  state_e              state_q;
  logic [IdxW-1:0]     idx_q;
  logic                trdy_q;
  logic                devsel_q;
  logic                ad_oe_q;
  logic [31:0]         ad_q;
  logic [31:0]         mem_q [MEM_WORDS];

  logic                addr_hit;
  logic                cmd_read;
  logic                cmd_write;
  logic                xfer;
  logic                wr_en;
  logic [IdxW-1:0]     idx_next;

  // Address decode and data-phase handshake qualifiers.
  always_comb begin
    addr_hit  = (AD[31:6] == BASE_ADDR[31:6]);
    cmd_read  = (bus.CBE == CmdMemRead);
    cmd_write = (bus.CBE == CmdMemWrite);
    // TRDY is only ever low in a data state, so this is a true transfer edge.
    xfer      = !bus.IRDY && !trdy_q;
    wr_en     = (state_q == StWriteData) && xfer;
    // Power-of-two depth makes natural overflow the wrap.
    idx_next  = idx_q + IdxW'(1);
  end

  // Transaction state machine; all bus outputs are registered here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      trdy_q   <= 1'b1;
      devsel_q <= 1'b1;
      ad_oe_q  <= 1'b0;
      ad_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!bus.FRAME) begin
            idx_q <= AD[IdxW+1:2];
            if (addr_hit && cmd_write) begin
              state_q  <= StWriteData;
              devsel_q <= 1'b0;
              trdy_q   <= 1'b0;
            end else if (addr_hit && cmd_read) begin
              state_q  <= StReadTa;
              devsel_q <= 1'b0;
            end else begin
              state_q <= StIgnore;
            end
          end
        end

        StWriteData: begin
          if (xfer) begin
            idx_q <= idx_next;
          end
          // FRAME high ends the burst, with or without a final transfer.
          if (bus.FRAME) begin
            state_q  <= StIdle;
            trdy_q   <= 1'b1;
            devsel_q <= 1'b1;
          end
        end

        StReadTa: begin
          // Initiator has released AD by now; start driving the first word.
          state_q <= StReadData;
          trdy_q  <= 1'b0;
          ad_oe_q <= 1'b1;
          ad_q    <= mem_q[idx_q];
        end

        StReadData: begin
          if (xfer) begin
            idx_q <= idx_next;
            ad_q  <= mem_q[idx_next];
          end
          if (bus.FRAME) begin
            state_q  <= StIdle;
            trdy_q   <= 1'b1;
            devsel_q <= 1'b1;
            ad_oe_q  <= 1'b0;
          end
        end

        StIgnore: begin
          if (bus.FRAME && bus.IRDY) begin
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Word memory: cleared by reset, written on write-phase transfers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
`ifdef BYTE_ENABLE_EN
      for (int b = 0; b < 4; b++) begin
        if (!bus.CBE[b]) begin
          mem_q[idx_q][8*b +: 8] <= AD[8*b +: 8];
        end
      end
`else
      mem_q[idx_q] <= AD;
`endif
    end
  end

  assign AD         = ad_oe_q ? ad_q : {32{1'bz}};
  assign bus.TRDY   = trdy_q;
  assign bus.DEVSEL = devsel_q;

endmodule

// File: tb/tb_pci_target_mem.sv
// tb_pci_target_mem: initiator model driving directed and randomized bursts
// into pci_target_mem, checked against a plain array model of the memory.
module tb_pci_target_mem;

  localparam logic [31:0] Base  = 32'hFFFF_0000;
  localparam logic [31:0] Probe = 32'h5A5A_A5A5;

  logic        clk;
  logic        rst;
  logic        m_oe;
  logic [31:0] m_ad;
  wire  [31:0] ad;

  pci_target_mem_if bus ();

  assign ad = m_oe ? m_ad : {32{1'bz}};

  pci_target_mem #(
    .BASE_ADDR(Base),
    .MEM_WORDS(16)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus),
    .AD (ad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model [16];
  int          n_checks;
  int          n_fail;

  logic [31:0] dq [$];
  logic [3:0]  bq [$];
  logic [31:0] addr;
  int          kind;
  int          len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a probe onto AD; it only reads back intact if the target is off the bus.
  task automatic check_released(input string tag);
    m_ad = Probe;
    m_oe = 1'b1;
    #1;
    check({tag, "_ad_released"}, ad, Probe);
    m_oe = 1'b0;
  endtask

  task automatic bus_idle();
    bus.FRAME = 1'b1;
    bus.IRDY  = 1'b1;
    bus.CBE   = 4'b0000;
    m_oe      = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [3:0] cmd,
                          input logic [31:0] data[$], input logic [3:0] be[$],
                          input int wait_pct);
    bit hit;
    int idx;
    int n;
    n   = data.size();
    hit = (a[31:6] == Base[31:6]) && (cmd == 4'b0111);
    idx = int'(a[5:2]);
    @(negedge clk);
    bus.FRAME = 1'b0;
    bus.CBE   = cmd;
    bus.IRDY  = 1'b1;
    m_ad      = a;
    m_oe      = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_devsel"}, 32'(bus.DEVSEL), hit ? 32'd0 : 32'd1);
      check({tag, "_trdy"}, 32'(bus.TRDY), hit ? 32'd0 : 32'd1);
      if (int'($urandom_range(0, 99)) < wait_pct) begin
        bus.IRDY  = 1'b1;
        bus.FRAME = 1'b0;
        bus.CBE   = 4'($urandom);
        m_ad      = $urandom;
        @(negedge clk);
        check({tag, "_wait_trdy"}, 32'(bus.TRDY), hit ? 32'd0 : 32'd1);
      end
      bus.IRDY  = 1'b0;
      bus.FRAME = (i == n - 1);
      bus.CBE   = be[i];
      m_ad      = data[i];
      if (hit) begin
`ifdef BYTE_ENABLE_EN
        for (int b = 0; b < 4; b++) begin
          if (!be[i][b]) model[idx][8*b +: 8] = data[i][8*b +: 8];
        end
`else
        model[idx] = data[i];
`endif
        idx = (idx + 1) % 16;
      end
    end
    @(negedge clk);
    check({tag, "_end_devsel"}, 32'(bus.DEVSEL), 32'd1);
    check({tag, "_end_trdy"}, 32'(bus.TRDY), 32'd1);
    bus_idle();
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input int n,
                         input int wait_pct);
    int idx;
    idx = int'(a[5:2]);
    @(negedge clk);
    bus.FRAME = 1'b0;
    bus.CBE   = 4'b0110;
    bus.IRDY  = 1'b1;
    m_ad      = a;
    m_oe      = 1'b1;
    @(negedge clk);
    // Turnaround: claimed but not yet ready, and AD must not be driven.
    check({tag, "_ta_devsel"}, 32'(bus.DEVSEL), 32'd0);
    check({tag, "_ta_trdy"}, 32'(bus.TRDY), 32'd1);
    bus.CBE = 4'b0000;
    check_released({tag, "_ta"});
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      check({tag, "_trdy"}, 32'(bus.TRDY), 32'd0);
      check({tag, "_data"}, ad, model[idx]);
      if (int'($urandom_range(0, 99)) < wait_pct) begin
        bus.IRDY  = 1'b1;
        bus.FRAME = 1'b0;
        @(negedge clk);
        check({tag, "_wait_data"}, ad, model[idx]);
      end
      bus.IRDY  = 1'b0;
      bus.FRAME = (i == n - 1);
      @(negedge clk);
      idx = (idx + 1) % 16;
    end
    check({tag, "_end_devsel"}, 32'(bus.DEVSEL), 32'd1);
    check({tag, "_end_trdy"}, 32'(bus.TRDY), 32'd1);
    check_released({tag, "_end"});
    bus_idle();
  endtask

  task automatic fill(input int n, input bit full_be);
    dq.delete();
    bq.delete();
    for (int i = 0; i < n; i++) begin
      dq.push_back($urandom);
      bq.push_back(full_be ? 4'b0000 : 4'($urandom));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    m_ad     = 32'h0;
    bus_idle();
    clear_model();

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_trdy", 32'(bus.TRDY), 32'd1);
    check("rst_devsel", 32'(bus.DEVSEL), 32'd1);
    check_released("rst");
    rst = 1'b0;
    do_read("rd_after_rst", Base, 1, 0);

    // Directed write burst at word 1, then one with wait states everywhere.
    dq = '{32'h0000_F0F0, 32'h0000_F0F1, 32'h0000_F0F2};
    bq = '{4'h0, 4'h0, 4'h0};
    do_write("wr_burst", 32'hFFFF_0004, 4'b0111, dq, bq, 0);
    dq = '{32'h1111_0004, 32'h1111_0005, 32'h1111_0006};
    do_write("wr_wait", 32'hFFFF_0010, 4'b0111, dq, bq, 100);
    do_read("rd_burst", 32'hFFFF_0004, 3, 0);
    do_read("rd_wait", 32'hFFFF_0010, 3, 100);

    // Address miss and unclaimed command leave memory untouched.
    dq = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
    bq = '{4'h0, 4'h0};
    do_write("wr_miss", 32'h1234_0000, 4'b0111, dq, bq, 0);
    do_write("wr_io_cmd", 32'hFFFF_0008, 4'b0011, dq, bq, 0);
    do_read("rd_all", Base, 16, 0);

    // Wrap from the last word.
    dq = '{32'hAAAA_000F, 32'hAAAA_0000, 32'hAAAA_0001};
    bq = '{4'h0, 4'h0, 4'h0};
    do_write("wr_wrap", 32'hFFFF_003C, 4'b0111, dq, bq, 0);
    do_read("rd_wrap", 32'hFFFF_003C, 4, 0);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 9));
      len  = int'($urandom_range(1, 6));
      addr = Base;
      addr[5:2] = 4'($urandom_range(0, 15));
      addr[1:0] = 2'($urandom_range(0, 3));
      if (kind < 5) begin
        fill(len, 1'b0);
        do_write("rnd_wr", addr, 4'b0111, dq, bq, 25);
      end else if (kind < 8) begin
        do_read("rnd_rd", addr, len, 25);
      end else if (kind == 8) begin
        addr = $urandom;
        if (addr[31:6] == Base[31:6]) addr[31] = ~addr[31];
        fill(len, 1'b1);
        do_write("rnd_miss", addr, 4'b0111, dq, bq, 25);
      end else begin
        fill(len, 1'b1);
        do_write("rnd_cmd", addr, 4'b0010, dq, bq, 25);
      end
    end
    do_read("rnd_final", Base, 16, 0);

    // Asynchronous reset in the middle of a read burst.
    @(negedge clk);
    bus.FRAME = 1'b0;
    bus.CBE   = 4'b0110;
    bus.IRDY  = 1'b1;
    m_ad      = 32'hFFFF_0004;
    m_oe      = 1'b1;
    @(negedge clk);
    m_oe     = 1'b0;
    bus.IRDY = 1'b0;
    @(negedge clk);
    check("mid_rst_pre_data", ad, model[1]);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_trdy", 32'(bus.TRDY), 32'd1);
    check("mid_rst_devsel", 32'(bus.DEVSEL), 32'd1);
    check_released("mid_rst");
    bus_idle();
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    do_read("rd_after_mid_rst", Base, 16, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pci_target_mem.md
Name:
pci_target_mem

Overview:
- Simplified 32-bit PCI target (slave) backed by a small internal word memory.
- Decodes the address phase on the shared multiplexed AD bus and claims matching Memory Read/Write transactions with DEVSEL#.
- Moves burst data using the IRDY#/TRDY# handshake.
- Sits on the PCI-style bus opposite a bus master/initiator model.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, base of claimed window; match when AD[31:6] == BASE_ADDR[31:6].
- MEM_WORDS, 16, depth of internal 32-bit memory; word index = address bits [5:2]; power of two.

Ports:
- CLK  input  1  bus clock; all sampling on rising edge.
- RST  input  1  reset; asynchronous, active-high.
- FRAME  input  1  active-low; initiator framing the transaction.
- AD  inout  32  multiplexed address/data; driven by target only during read data phases, else hi-Z.
- CBE  input  4  command in address phase, byte enables (active-low) in data phases.
- IRDY  input  1  active-low initiator ready.
- TRDY  output  1  active-low target ready.
- DEVSEL  output  1  active-low device select.

Behaviour:
- Reset, while RST=1: TRDY=1, DEVSEL=1, AD hi-Z, state IDLE, all memory words = 0. Reset mid-transaction aborts immediately; outputs released asynchronously.
- Commands decoded: CBE=4'b0110 Memory Read, 4'b0111 Memory Write. All other commands are not claimed.
- State machine: IDLE, WRITE_DATA, READ_TA (turnaround), READ_DATA, IGNORE.
- IDLE, rising edge with FRAME=0:
  - Latch word index AD[5:2]; AD[1:0] ignored.
  - Address match and Memory Write -> WRITE_DATA; DEVSEL and TRDY go low after that edge.
  - Address match and Memory Read -> READ_TA; DEVSEL low, TRDY stays high.
  - Otherwise -> IGNORE.
- READ_TA: one turnaround cycle. At the next edge -> READ_DATA: TRDY low, AD driven with mem[index].
- Data transfer occurs on each rising edge where IRDY=0 and TRDY=0.
  - Write: mem[index] <= AD.
  - Read: the initiator captures the driven word.
  - After each transfer, index increments by 1 and wraps modulo MEM_WORDS. In a read, AD updates to the new mem[index] in the same cycle.
- IRDY=1 is an initiator wait state: no transfer, index unchanged, TRDY/DEVSEL held, read data held stable on AD.
- Target never inserts wait states after the first data phase.
- Last data phase: FRAME=1 with IRDY=0. On that transfer edge go to IDLE, set TRDY=1 and DEVSEL=1, release AD to hi-Z.
- FRAME=1 with IRDY=1 while in a data state is also treated as end: return to IDLE and release.
- IGNORE: no outputs driven. Return to IDLE on the first edge where FRAME=1 and IRDY=1.
- Bus idle (FRAME=1 and IRDY=1) in IDLE: stay idle.
- AD output enable is asserted only in READ_DATA, never in READ_TA, so there is no contention with the initiator.

Optional Feature:
- Macro BYTE_ENABLE_EN.
- Defined: during write transfers only byte lanes with CBE[i]=0 are written (lane i = AD[8i+7:8i]); CBE=4'b1111 writes nothing but the index still advances. Reads always return full words.
- Undefined: CBE is ignored during data phases; every write transfer writes all 32 bits.

Test Plan:
- Reset: RST=1 -> TRDY=1, DEVSEL=1, AD=Z; then read from 0xFFFF_0000 returns 0x0000_0000.
- Write burst: FRAME=0, CBE=0111, AD=0xFFFF_0004, then data 0x0000_F0F0, F0F1, F0F2 with IRDY=0, last phase FRAME=1.
  - DEVSEL/TRDY low one cycle after address.
  - Words 1..3 written.
  - Both outputs high after final transfer.
- Initiator wait state: mid-burst IRDY=1 for one cycle while AD changes -> no write that cycle, next IRDY=0 data lands at the following index.
- Read burst: CBE=0110 at 0xFFFF_0004, AD released by initiator.
  - TRDY low one cycle after DEVSEL (turnaround).
  - AD returns 0x0000_F0F0 then 0x0000_F0F1.
  - AD hi-Z after last phase.
- Address miss: write to 0x1234_0000 -> DEVSEL/TRDY stay high, memory unchanged.
- Wrap and reset: a burst of 3 writes starting at index 15 writes indices 15, 0, 1. RST=1 mid-burst immediately releases TRDY/DEVSEL/AD and clears memory.
